ld_rs: RTL and testbench

Load reservation station for the Tomasulo core. It buffers up to NUM_ENTRIES issued LD/LDR instructions and captures missing source operands from the common data bus (CDB). It dispatches one operand-complete instruction at a time into the `ld` unit. Each entry's tag stays reserved until the `ld` unit broadcasts that entry's result on the CDB.

---
 rtl/ld_rs.sv | 183 ++++++++++++++++++
 tb/tb_ld_rs.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ld_rs.sv
// Load reservation station: buffers issued LD/LDR ops, captures operands from the CDB,
// and dispatches one operand-complete entry at a time to the ld unit.
module ld_rs #(
    parameter int unsigned NUM_ENTRIES = 4,
    parameter logic [5:0]  RS_BASE     = 6'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [3:0]  issue_op,
    input  logic        issue_rdy0,
    input  logic        issue_rdy1,
    input  logic [15:0] issue_val0,
    input  logic [15:0] issue_val1,
    input  logic [5:0]  issue_tag0,
    input  logic [5:0]  issue_tag1,
    output logic        issue_full,
    output logic [5:0]  issue_rs_num,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [15:0] cdb_data,
    output logic        valid,
    output logic [5:0]  rs_num,
    output logic [3:0]  op,
    output logic [15:0] val0,
    output logic [15:0] val1,
    input  logic        ld_busy
);

    localparam int unsigned DW    = 16;
    localparam int unsigned TW    = 6;
    localparam int unsigned OW    = 4;
    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    typedef struct packed {
        logic [OW-1:0] op;
        logic          rdy0;
        logic          rdy1;
        logic [TW-1:0] tag0;
        logic [TW-1:0] tag1;
        logic [DW-1:0] val0;
        logic [DW-1:0] val1;
    } entry_t;

    state_t            r_state [NUM_ENTRIES];
    entry_t            r_ent   [NUM_ENTRIES];

    logic              r_valid;
    logic [TW-1:0]     r_rs_num;
    logic [OW-1:0]     r_op;
    logic [DW-1:0]     r_val0;
    logic [DW-1:0]     r_val1;

    logic              w_any_free;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_any_ready;
    logic [IDX_W-1:0]  w_ready_idx;
    logic              w_issue;
    logic              w_dispatch;
    logic              w_new_rdy0;
    logic              w_new_rdy1;
    logic [DW-1:0]     w_new_val0;
    logic [DW-1:0]     w_new_val1;
    logic              w_hit0  [NUM_ENTRIES];
    logic              w_hit1  [NUM_ENTRIES];

    // Lowest-index FREE and READY entries, from registered state only
    always_comb begin
        w_any_free  = 1'b0;
        w_free_idx  = '0;
        w_any_ready = 1'b0;
        w_ready_idx = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_state[i] == ST_READY) begin
                w_any_ready = 1'b1;
                w_ready_idx = IDX_W'(i);
            end
        end
    end

    // CDB operand match for every entry still waiting on an operand
    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            w_hit0[i] = cdb_valid && (r_state[i] == ST_WAIT) && !r_ent[i].rdy0 &&
                        (r_ent[i].tag0 == cdb_tag);
            w_hit1[i] = cdb_valid && (r_state[i] == ST_WAIT) && !r_ent[i].rdy1 &&
                        (r_ent[i].tag1 == cdb_tag);
        end
    end

    assign issue_full   = !w_any_free;
    assign issue_rs_num = RS_BASE + TW'(w_free_idx);
    assign w_issue      = issue_valid && w_any_free;
    assign w_dispatch   = !ld_busy && !r_valid && w_any_ready;

    // Issue-cycle bypass: a broadcast of the producing tag in the issue cycle counts as ready
    assign w_new_rdy0 = issue_rdy0 || (cdb_valid && (cdb_tag == issue_tag0));
    assign w_new_rdy1 = issue_rdy1 || (cdb_valid && (cdb_tag == issue_tag1));
    assign w_new_val0 = issue_rdy0 ? issue_val0 : cdb_data;
    assign w_new_val1 = issue_rdy1 ? issue_val1 : cdb_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                r_state[i] <= ST_FREE;
                r_ent[i]   <= '0;
            end
            r_valid  <= 1'b0;
            r_rs_num <= '0;
            r_op     <= '0;
            r_val0   <= '0;
            r_val1   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                case (r_state[i])
                    ST_FREE: begin
                        if (w_issue && (w_free_idx == IDX_W'(i))) begin
                            r_ent[i].op   <= issue_op;
                            r_ent[i].tag0 <= issue_tag0;
                            r_ent[i].tag1 <= issue_tag1;
                            r_ent[i].rdy0 <= w_new_rdy0;
                            r_ent[i].rdy1 <= w_new_rdy1;
                            r_ent[i].val0 <= w_new_val0;
                            r_ent[i].val1 <= w_new_val1;
                            r_state[i]    <= (w_new_rdy0 && w_new_rdy1) ? ST_READY : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (w_hit0[i]) begin
                            r_ent[i].rdy0 <= 1'b1;
                            r_ent[i].val0 <= cdb_data;
                        end
                        if (w_hit1[i]) begin
                            r_ent[i].rdy1 <= 1'b1;
                            r_ent[i].val1 <= cdb_data;
                        end
                        if ((r_ent[i].rdy0 || w_hit0[i]) && (r_ent[i].rdy1 || w_hit1[i])) begin
                            r_state[i] <= ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (w_dispatch && (w_ready_idx == IDX_W'(i))) begin
                            r_state[i] <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        if (cdb_valid && (cdb_tag == (RS_BASE + TW'(i)))) begin
                            r_state[i] <= ST_FREE;
                        end
                    end
                    default: r_state[i] <= ST_FREE;
                endcase
            end

            // One-cycle dispatch pulse; holding off while valid spaces dispatches 2 cycles apart
            r_valid <= w_dispatch;
            if (w_dispatch) begin
                r_rs_num <= RS_BASE + TW'(w_ready_idx);
                r_op     <= r_ent[w_ready_idx].op;
                r_val0   <= r_ent[w_ready_idx].val0;
                r_val1   <= r_ent[w_ready_idx].val1;
            end
        end
    end

    assign valid  = r_valid;
    assign rs_num = r_rs_num;
    assign op     = r_op;
    assign val0   = r_val0;
    assign val1   = r_val1;

endmodule

// File: tb/tb_ld_rs.sv
// Directed bench for ld_rs: vector table for issue/wakeup/bypass, hand sequences for
// full/retire, arbitration under ld_busy and reset in mid-dispatch.
module tb_ld_rs;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [3:0]  issue_op;
    logic        issue_rdy0;
    logic        issue_rdy1;
    logic [15:0] issue_val0;
    logic [15:0] issue_val1;
    logic [5:0]  issue_tag0;
    logic [5:0]  issue_tag1;
    logic        issue_full;
    logic [5:0]  issue_rs_num;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        valid;
    logic [5:0]  rs_num;
    logic [3:0]  op;
    logic [15:0] val0;
    logic [15:0] val1;
    logic        ld_busy;

    int checks   = 0;
    int failures = 0;

    ld_rs #(.NUM_ENTRIES(4), .RS_BASE(6'd8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .issue_rdy0   (issue_rdy0),
        .issue_rdy1   (issue_rdy1),
        .issue_val0   (issue_val0),
        .issue_val1   (issue_val1),
        .issue_tag0   (issue_tag0),
        .issue_tag1   (issue_tag1),
        .issue_full   (issue_full),
        .issue_rs_num (issue_rs_num),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .valid        (valid),
        .rs_num       (rs_num),
        .op           (op),
        .val0         (val0),
        .val1         (val1),
        .ld_busy      (ld_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [3:0]  op;
        logic        r0;
        logic [15:0] v0;
        logic [5:0]  t0;
        logic        r1;
        logic [15:0] v1;
        logic [5:0]  t1;
        logic        cv;
        logic [5:0]  ct;
        logic [15:0] cd;
        logic        e_valid;
        logic [5:0]  e_rs;
        logic [3:0]  e_op;
        logic [15:0] e_v0;
        logic [15:0] e_v1;
        logic [5:0]  e_irs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic iv, input logic [3:0] o,
        input logic r0, input logic [15:0] v0, input logic [5:0] t0,
        input logic r1, input logic [15:0] v1, input logic [5:0] t1,
        input logic cv, input logic [5:0] ct, input logic [15:0] cd,
        input logic ev, input logic [5:0] ers, input logic [3:0] eop,
        input logic [15:0] ev0, input logic [15:0] ev1, input logic [5:0] eirs);
        vec_t v;
        v.iv = iv; v.op = o; v.r0 = r0; v.v0 = v0; v.t0 = t0;
        v.r1 = r1; v.v1 = v1; v.t1 = t1; v.cv = cv; v.ct = ct; v.cd = cd;
        v.e_valid = ev; v.e_rs = ers; v.e_op = eop; v.e_v0 = ev0; v.e_v1 = ev1; v.e_irs = eirs;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_op = 4'd0;
        issue_rdy0 = 1'b0; issue_rdy1 = 1'b0;
        issue_val0 = '0; issue_val1 = '0; issue_tag0 = '0; issue_tag1 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic issue_ready(input logic [3:0] o, input logic [15:0] v0, input logic [15:0] v1);
        idle();
        issue_valid = 1'b1; issue_op = o;
        issue_rdy0 = 1'b1; issue_val0 = v0;
        issue_rdy1 = 1'b1; issue_val1 = v1;
    endtask

    task automatic cdb(input logic [5:0] t, input logic [15:0] d);
        idle();
        cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        ld_busy = 1'b0;
        rst_n   = 1'b0;

        // Reset / idle
        do_reset();
        chk("reset valid", 16'(valid), 16'd0);
        chk("reset full", 16'(issue_full), 16'd0);
        chk("reset irs", 16'(issue_rs_num), 16'd8);
        chk("reset rs_num", 16'(rs_num), 16'd0);
        chk("reset op", 16'(op), 16'd0);
        chk("reset val0", val0, 16'd0);
        chk("reset val1", val1, 16'd0);

        // Issue, wakeup, bypass and opcode pass-through vectors
        tbl.push_back(mk(1,4'd4, 1,16'h0010,6'd0, 1,16'h0000,6'd0, 0,6'd0,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 0,6'd0,16'h0000, 1,6'd8,4'd4,16'h0010,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 0,6'd0,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 1,6'd8,16'h1234, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd8));
        tbl.push_back(mk(1,4'd5, 0,16'h0000,6'd3, 1,16'h0005,6'd0, 0,6'd0,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 0,6'd0,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 1,6'd3,16'h0100, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 0,6'd0,16'h0000, 1,6'd8,4'd5,16'h0100,16'h0005, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 0,6'd0,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 1,6'd8,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd8));
        tbl.push_back(mk(1,4'd5, 0,16'h0000,6'd3, 1,16'h0007,6'd0, 1,6'd3,16'h0ABC, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 0,6'd0,16'h0000, 1,6'd8,4'd5,16'h0ABC,16'h0007, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 1,6'd8,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd8));
        tbl.push_back(mk(1,4'd4, 1,16'h0022,6'd0, 0,16'h0000,6'd20, 1,6'd21,16'h5555, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 1,6'd20,16'h0033, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 0,6'd0,16'h0000, 1,6'd8,4'd4,16'h0022,16'h0033, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 1,6'd8,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd8));
        tbl.push_back(mk(1,4'hA, 1,16'h0001,6'd0, 1,16'h0002,6'd0, 0,6'd0,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 0,6'd0,16'h0000, 1,6'd8,4'hA,16'h0001,16'h0002, 6'd9));
        tbl.push_back(mk(0,4'd0, 0,16'h0000,6'd0, 0,16'h0000,6'd0, 1,6'd8,16'h0000, 0,6'd0,4'd0,16'h0000,16'h0000, 6'd8));

        foreach (tbl[k]) begin
            issue_valid = tbl[k].iv; issue_op = tbl[k].op;
            issue_rdy0 = tbl[k].r0; issue_val0 = tbl[k].v0; issue_tag0 = tbl[k].t0;
            issue_rdy1 = tbl[k].r1; issue_val1 = tbl[k].v1; issue_tag1 = tbl[k].t1;
            cdb_valid = tbl[k].cv; cdb_tag = tbl[k].ct; cdb_data = tbl[k].cd;
            tick();
            chk($sformatf("row%0d valid", k), 16'(valid), 16'(tbl[k].e_valid));
            chk($sformatf("row%0d full", k), 16'(issue_full), 16'd0);
            chk($sformatf("row%0d irs", k), 16'(issue_rs_num), 16'(tbl[k].e_irs));
            if (tbl[k].e_valid) begin
                chk($sformatf("row%0d rs_num", k), 16'(rs_num), 16'(tbl[k].e_rs));
                chk($sformatf("row%0d op", k), 16'(op), 16'(tbl[k].e_op));
                chk($sformatf("row%0d val0", k), val0, tbl[k].e_v0);
                chk($sformatf("row%0d val1", k), val1, tbl[k].e_v1);
            end
        end
        idle();

        // Fill all entries while ld is busy, refuse a 5th, retire tag 8
        do_reset();
        ld_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue_ready(4'd4, 16'h0100 + 16'(k), 16'(k));
            chk($sformatf("fill irs%0d", k), 16'(issue_rs_num), 16'(8 + k));
            tick();
        end
        idle();
        chk("fill full", 16'(issue_full), 16'd1);
        issue_ready(4'd4, 16'h0BAD, 16'h0000);
        tick();
        idle();
        chk("refused full", 16'(issue_full), 16'd1);
        chk("refused valid", 16'(valid), 16'd0);
        ld_busy = 1'b0;
        tick();
        chk("fill disp valid", 16'(valid), 16'd1);
        chk("fill disp rs", 16'(rs_num), 16'd8);
        chk("fill disp val0", val0, 16'h0100);
        ld_busy = 1'b1;
        tick();
        chk("fill pulse end", 16'(valid), 16'd0);
        cdb(6'd8, 16'h7777);
        issue_valid = 1'b1; issue_rdy0 = 1'b1; issue_rdy1 = 1'b1; issue_op = 4'd4;
        tick();
        idle();
        chk("retire full", 16'(issue_full), 16'd0);
        chk("retire irs", 16'(issue_rs_num), 16'd8);
        issue_ready(4'd4, 16'h0200, 16'h0000);
        tick();
        idle();
        chk("realloc full", 16'(issue_full), 16'd1);
        ld_busy = 1'b0;
        tick();
        chk("realloc valid", 16'(valid), 16'd1);
        chk("realloc rs", 16'(rs_num), 16'd8);
        chk("realloc val0", val0, 16'h0200);

        // Arbitration: entry 0 waits, entries 1 and 2 ready behind ld_busy
        do_reset();
        ld_busy = 1'b1;
        idle();
        issue_valid = 1'b1; issue_op = 4'd5; issue_tag0 = 6'd40; issue_rdy1 = 1'b1;
        tick();
        issue_ready(4'd4, 16'h0011, 16'h0000);
        tick();
        issue_ready(4'd4, 16'h0022, 16'h0000);
        tick();
        idle();
        tick();
        chk("busy hold valid", 16'(valid), 16'd0);
        ld_busy = 1'b0;
        tick();
        chk("arb1 valid", 16'(valid), 16'd1);
        chk("arb1 rs", 16'(rs_num), 16'd9);
        chk("arb1 val0", val0, 16'h0011);
        tick();
        chk("arb gap valid", 16'(valid), 16'd0);
        tick();
        chk("arb2 valid", 16'(valid), 16'd1);
        chk("arb2 rs", 16'(rs_num), 16'd10);
        chk("arb2 val0", val0, 16'h0022);

        // Reset during a dispatch pulse with three entries occupied
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst valid", 16'(valid), 16'd0);
        chk("midrst full", 16'(issue_full), 16'd0);
        chk("midrst irs", 16'(issue_rs_num), 16'd8);
        chk("midrst rs", 16'(rs_num), 16'd0);
        chk("midrst val0", val0, 16'd0);
        cdb(6'd40, 16'h4444);
        tick();
        chk("midrst wake valid", 16'(valid), 16'd0);
        cdb(6'd9, 16'h9999);
        tick();
        idle();
        tick();
        chk("midrst tag9 valid", 16'(valid), 16'd0);
        chk("midrst tag9 irs", 16'(issue_rs_num), 16'd8);
        ld_busy = 1'b1;
        issue_ready(4'd4, 16'h0001, 16'h0000);
        tick();
        issue_ready(4'd5, 16'h0002, 16'h0000);
        tick();
        idle();
        chk("post irs", 16'(issue_rs_num), 16'd10);
        cdb(6'd9, 16'h9999);
        tick();
        idle();
        chk("ready not retired", 16'(issue_rs_num), 16'd10);
        ld_busy = 1'b0;
        tick();
        chk("post valid", 16'(valid), 16'd1);
        chk("post rs", 16'(rs_num), 16'd8);
        chk("post val0", val0, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
